mt6835_spi_slave_emu: RTL and testbench
=======================================

Name: mt6835_spi_slave_emu

Overview:
Synthesizable SPI responder that emulates the MT6835 angle-read interface. It lets the FOC SPI master be exercised in simulation and hardware-in-loop without a real encoder. It decodes the 8-bit READ ANGLE command 0x83 and returns a 32-bit frame: angle[20:0], status[2:0], CRC[7:0]. Angle and status come from user logic and are snapshotted at command accept.

Parameters:
CMD_READ_ANGLE, 8'h83, the only command byte the block accepts.
SYNC_STAGES, 2, synchronizer depth for spi_cs, spi_sck and spi_mosi (legal range 2..3).

Ports:
i_clk  in  1  system clock; all logic is on its rising edge.
i_rst  in  1  reset, asynchronous, active-high.
spi_cs  in  1  chip select from the master, active-low.
spi_sck  in  1  SPI clock from the master; idles low.
spi_mosi  in  1  command bits, MSB first.
spi_miso  out  1  response bits, MSB first; driven 1 when not sending data.
o_miso_oe  out  1  output enable for an external tristate; 1 only while a response is in progress.
i_angle  in  21  angle value to serve.
i_status  in  3  status value to serve.
i_update  in  1  1-cycle strobe that loads i_angle and i_status into the shadow register.
o_cmd_valid  out  1  1-cycle pulse when a good command is accepted.
o_cmd_err  out  1  1-cycle pulse when a command byte other than CMD_READ_ANGLE is received.
o_frame_done  out  1  1-cycle pulse when spi_cs rises after all 32 response bits were sent.
o_busy  out  1  1 whenever the state is not IDLE.

Behaviour:
- Reset: state=IDLE, spi_miso=1, o_miso_oe=0, all pulses 0, o_busy=0. Shadow register = {21'h0, 3'h0, 8'h00}.
- Input sync: spi_cs, spi_sck and spi_mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronized copies.
- Timing requirement: SCK half-period must be at least 2*SYNC_STAGES+2 i_clk cycles.
- SPI mode 0:
  - MOSI is sampled on the synchronized SCK rising edge.
  - MISO is updated on the synchronized SCK falling edge.
- Shadow register:
  - On i_update it loads {i_angle, i_status, crc8(i_angle, i_status)}.
  - CRC: polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR, computed over the 24 bits {angle, status} MSB first. It is combinational from the inputs and registered into the shadow.
- FSM:
  - IDLE: spi_cs falling -> CMD, bit counter cleared.
  - CMD: shift MOSI on each rising edge. On the 8th rising edge:
    - byte == CMD_READ_ANGLE: snapshot shadow -> tx register, pulse o_cmd_valid, -> RESP.
    - otherwise: pulse o_cmd_err, -> WAIT_CS.
  - RESP: o_miso_oe=1.
    - On each falling edge, drive tx[31] and shift left.
    - After the 32nd bit has been held through its rising edge (32 rising edges counted in RESP) -> WAIT_CS, with the full flag set.
  - WAIT_CS: spi_miso=1, o_miso_oe=0. Extra SCK edges are ignored. spi_cs rising -> IDLE; pulse o_frame_done only if the full flag is set.
- Latency: the first response bit (tx[31]) appears on the falling edge right after the 8th command rising edge, plus SYNC_STAGES+1 i_clk cycles.
- spi_cs rising in CMD or RESP (abort): return to IDLE the next cycle, spi_miso=1, o_miso_oe=0, no o_frame_done, shadow untouched.
- i_update in the same cycle as the snapshot: the snapshot takes the pre-update shadow; the new value is served on the next frame.
- spi_cs low at reset release: the block stays in IDLE until a fresh spi_cs falling edge.
- Asserting i_rst mid-frame: immediate return to reset values.

Optional Feature:
MT6835_EMU_CRC_ERR_INJ_EN
- Defined: adds input i_crc_inj (1 bit). It is sampled at snapshot; if 1, the CRC byte of that frame is bitwise inverted. This exercises master CRC checking.
- Undefined: the port and the logic are absent; the CRC is always correct.

Test Plan:
1. Reset, then i_update with angle=0, status=0; master sends 0x83 -> MISO frame 0x00000000, o_cmd_valid once, o_frame_done once after spi_cs rises.
2. i_update with angle=21'h1FFFFF, status=3'b111; read -> frame 0xFFFFFF0F (CRC 0x0F).
3. Command 0x03 -> o_cmd_err pulse, o_miso_oe stays 0, MISO stays 1 for 32 clocks, no o_frame_done.
4. spi_cs deasserted after 12 response bits -> o_miso_oe=0 within SYNC_STAGES+2 cycles, no o_frame_done; the next full read returns the correct frame.
5. i_update pulsed in the snapshot cycle with a new angle -> the current frame holds the old angle, the next frame holds the new one.
6. With MT6835_EMU_CRC_ERR_INJ_EN defined, i_crc_inj=1, angle=0, status=0 -> frame 0x000000FF.

Source files
------------

// File: rtl/mt6835_spi_slave_emu_if.sv
// Signal bundle between an SPI master/user logic and the MT6835 angle-read emulator.
// Optional member i_crc_inj exists only when MT6835_EMU_CRC_ERR_INJ_EN is defined.
interface mt6835_spi_slave_emu_if;
    logic        spi_cs;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        o_miso_oe;
    logic [20:0] i_angle;
    logic [2:0]  i_status;
    logic        i_update;
`ifdef MT6835_EMU_CRC_ERR_INJ_EN
    logic        i_crc_inj;
`endif
    logic        o_cmd_valid;
    logic        o_cmd_err;
    logic        o_frame_done;
    logic        o_busy;

    modport slave (
        input  spi_cs, spi_sck, spi_mosi, i_angle, i_status, i_update,
`ifdef MT6835_EMU_CRC_ERR_INJ_EN
               i_crc_inj,
`endif
        output spi_miso, o_miso_oe, o_cmd_valid, o_cmd_err, o_frame_done, o_busy
    );

    modport master (
        output spi_cs, spi_sck, spi_mosi, i_angle, i_status, i_update,
`ifdef MT6835_EMU_CRC_ERR_INJ_EN
               i_crc_inj,
`endif
        input  spi_miso, o_miso_oe, o_cmd_valid, o_cmd_err, o_frame_done, o_busy
    );
endinterface

// File: rtl/mt6835_spi_slave_emu.sv
// SPI mode-0 responder emulating the MT6835 READ ANGLE command (angle, status, CRC-8 frame).
// Define MT6835_EMU_CRC_ERR_INJ_EN to add i_crc_inj, which inverts the CRC byte of a frame.
module mt6835_spi_slave_emu #(
    parameter logic [7:0] CMD_READ_ANGLE = 8'h83,
    parameter int         SYNC_STAGES    = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    mt6835_spi_slave_emu_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, CMD, RESP, WAIT_CS} state_t;

    // Bit order in each sync stage: {cs, sck, mosi}.
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic                        cs_prev_q, sck_prev_q;
    logic                        cs_s, sck_s, mosi_s;
    logic                        cs_rise, cs_fall, sck_rise, sck_fall;

    state_t      state_q;
    logic [4:0]  bit_cnt_q;
    logic [7:0]  cmd_q;
    logic [31:0] tx_q;
    logic [31:0] shadow_q;
    logic [31:0] shadow_d;
    logic [7:0]  crc_mask;
    logic [7:0]  cmd_byte;
    logic        miso_q, oe_q, cmd_valid_q, cmd_err_q, frame_done_q, full_q;

    function automatic logic [7:0] crc8(input logic [23:0] data);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 23; i >= 0; i--) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ data[i]) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    assign cs_s     = sync_q[SYNC_STAGES-1][2];
    assign sck_s    = sync_q[SYNC_STAGES-1][1];
    assign mosi_s   = sync_q[SYNC_STAGES-1][0];
    assign cs_rise  =  cs_s  & ~cs_prev_q;
    assign cs_fall  = ~cs_s  &  cs_prev_q;
    assign sck_rise =  sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s &  sck_prev_q;

    assign shadow_d = {bus.i_angle, bus.i_status, crc8({bus.i_angle, bus.i_status})};
    assign cmd_byte = {cmd_q[6:0], mosi_s};

`ifdef MT6835_EMU_CRC_ERR_INJ_EN
    assign crc_mask = {8{bus.i_crc_inj}};
`else
    assign crc_mask = 8'h00;
`endif

    // cs resets to "asserted" so a cs held low across reset release never looks like a fresh falling edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q     <= '0;
            cs_prev_q  <= 1'b0;
            sck_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], {bus.spi_cs, bus.spi_sck, bus.spi_mosi}};
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            cmd_q        <= '0;
            tx_q         <= '0;
            shadow_q     <= '0;
            miso_q       <= 1'b1;
            oe_q         <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            cmd_valid_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.i_update) begin
                shadow_q <= shadow_d;
            end
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q   <= CMD;
                        bit_cnt_q <= '0;
                        full_q    <= 1'b0;
                    end
                end
                CMD: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                    end else if (sck_rise) begin
                        cmd_q     <= cmd_byte;
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            if (cmd_byte == CMD_READ_ANGLE) begin
                                // Snapshot uses the registered shadow, so a same-cycle update waits for the next frame.
                                tx_q        <= {shadow_q[31:8], shadow_q[7:0] ^ crc_mask};
                                cmd_valid_q <= 1'b1;
                                oe_q        <= 1'b1;
                                bit_cnt_q   <= '0;
                                state_q     <= RESP;
                            end else begin
                                cmd_err_q <= 1'b1;
                                state_q   <= WAIT_CS;
                            end
                        end
                    end
                end
                RESP: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        miso_q  <= 1'b1;
                        oe_q    <= 1'b0;
                    end else begin
                        if (sck_fall) begin
                            miso_q <= tx_q[31];
                            tx_q   <= {tx_q[30:0], 1'b0};
                        end
                        if (sck_rise) begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd31) begin
                                state_q <= WAIT_CS;
                                full_q  <= 1'b1;
                                miso_q  <= 1'b1;
                                oe_q    <= 1'b0;
                            end
                        end
                    end
                end
                WAIT_CS: begin
                    if (cs_rise) begin
                        state_q      <= IDLE;
                        frame_done_q <= full_q;
                        full_q       <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.spi_miso     = miso_q;
    assign bus.o_miso_oe    = oe_q;
    assign bus.o_cmd_valid  = cmd_valid_q;
    assign bus.o_cmd_err    = cmd_err_q;
    assign bus.o_frame_done = frame_done_q;
    assign bus.o_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mt6835_spi_slave_emu.sv
// Scoreboard bench for mt6835_spi_slave_emu: stimulus pushes expected MISO frames, a monitor
// captures MISO on each SCK rise while o_miso_oe is high and compares when spi_cs rises.
module tb_mt6835_spi_slave_emu;
    localparam int HALF = 8;

    typedef struct {
        logic [31:0] frame;
        int          nbits;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mt6835_spi_slave_emu_if bus();

    mt6835_spi_slave_emu #(.CMD_READ_ANGLE(8'h83), .SYNC_STAGES(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_valid = 0, n_err = 0, n_done = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_cmd_valid)  n_valid++;
            if (bus.o_cmd_err)    n_err++;
            if (bus.o_frame_done) n_done++;
        end
    end

    // Monitor: one cs-low window per scoreboard entry.
    initial begin : monitor
        forever begin
            logic [31:0] cap;
            logic [31:0] want;
            int          cnt;
            exp_t        e;
            @(negedge bus.spi_cs);
            cap = '0;
            cnt = 0;
            while (bus.spi_cs === 1'b0) begin
                @(posedge bus.spi_sck or posedge bus.spi_cs);
                if (bus.spi_cs === 1'b0 && bus.o_miso_oe === 1'b1) begin
                    cap = {cap[30:0], bus.spi_miso};
                    cnt++;
                end
            end
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL frame: unexpected cs window, got %0d bits %h expected none", cnt, cap);
            end else begin
                e    = sb_q.pop_front();
                want = (e.nbits == 0) ? 32'h0 : (e.frame >> (32 - e.nbits));
                if (cnt != e.nbits || cap !== want) begin
                    errors++;
                    $display("FAIL %s: got %0d bits %h expected %0d bits %h", e.name, cnt, cap, e.nbits, want);
                end else begin
                    $display("frame %s: %0d bits %h", e.name, cnt, cap);
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCK period; optionally pulses i_update in the cycle the DUT acts on this rising edge.
    task automatic sck_pulse(logic mosi_bit, bit upd_snap, logic [20:0] na, logic [2:0] ns);
        bus.spi_mosi = mosi_bit;
        cyc(HALF);
        bus.spi_sck = 1'b1;
        if (upd_snap) begin
            cyc(2);
            bus.i_angle  = na;
            bus.i_status = ns;
            bus.i_update = 1'b1;
            cyc(1);
            bus.i_update = 1'b0;
            cyc(HALF - 3);
        end else begin
            cyc(HALF);
        end
        bus.spi_sck = 1'b0;
    endtask

    task automatic send_cmd(logic [7:0] cmd, bit upd_snap, logic [20:0] na, logic [2:0] ns);
        bus.spi_cs = 1'b0;
        cyc(HALF);
        for (int i = 7; i >= 0; i--) begin
            sck_pulse(cmd[i], upd_snap && (i == 0), na, ns);
        end
    endtask

    task automatic clock_bits(int n);
        for (int i = 0; i < n; i++) sck_pulse(1'b0, 1'b0, '0, '0);
    endtask

    task automatic end_cs();
        cyc(HALF);
        bus.spi_cs = 1'b1;
        cyc(2 * HALF);
    endtask

    task automatic update(logic [20:0] a, logic [2:0] s);
        bus.i_angle  = a;
        bus.i_status = s;
        bus.i_update = 1'b1;
        cyc(1);
        bus.i_update = 1'b0;
        cyc(1);
    endtask

    task automatic read_frame(string name, logic [31:0] exp, int nclk,
                              bit upd_snap, logic [20:0] na, logic [2:0] ns);
        int v0, e0, d0;
        v0 = n_valid; e0 = n_err; d0 = n_done;
        sb_q.push_back('{exp, 32, name});
        send_cmd(8'h83, upd_snap, na, ns);
        clock_bits(nclk);
        end_cs();
        $display("txn %s: cmd=83 clocks=%0d expect=%h", name, nclk, exp);
        chk({name, "_valid"}, n_valid - v0, 1);
        chk({name, "_done"},  n_done - d0, 1);
        chk({name, "_err"},   n_err - e0, 0);
    endtask

    initial begin : watchdog
        #3_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stim
        int  v0, e0, d0;
        logic bad;
        bus.spi_cs   = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.i_angle  = '0;
        bus.i_status = '0;
        bus.i_update = 1'b0;
`ifdef MT6835_EMU_CRC_ERR_INJ_EN
        bus.i_crc_inj = 1'b0;
`endif
        cyc(5);
        chk("rst_miso",  bus.spi_miso, 1);
        chk("rst_oe",    bus.o_miso_oe, 0);
        chk("rst_busy",  bus.o_busy, 0);
        chk("rst_pulses", {bus.o_cmd_valid, bus.o_cmd_err, bus.o_frame_done}, 0);
        rst = 1'b0;
        cyc(5);

        update(21'h0, 3'h0);
        read_frame("zero", 32'h0000_0000, 32, 0, '0, '0);

        update(21'h1FFFFF, 3'h7);
        read_frame("ones_extra_sck", 32'hFFFF_FF0F, 34, 0, '0, '0);

        // Bad command: error pulse, MISO idle, no frame_done.
        v0 = n_valid; e0 = n_err; d0 = n_done;
        sb_q.push_back('{32'h0, 0, "badcmd"});
        send_cmd(8'h03, 0, '0, '0);
        bad = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (bus.spi_miso !== 1'b1 || bus.o_miso_oe !== 1'b0) bad = 1'b1;
            cyc(1);
        end
        chk("badcmd_idle_miso", bad, 0);
        chk("badcmd_busy", bus.o_busy, 1);
        clock_bits(4);
        end_cs();
        $display("txn badcmd: cmd=03");
        chk("badcmd_err",   n_err - e0, 1);
        chk("badcmd_valid", n_valid - v0, 0);
        chk("badcmd_done",  n_done - d0, 0);

        // Abort after 12 response bits.
        v0 = n_valid; d0 = n_done;
        sb_q.push_back('{32'hFFFF_FF0F, 12, "abort12"});
        send_cmd(8'h83, 0, '0, '0);
        clock_bits(12);
        cyc(HALF);
        bus.spi_cs = 1'b1;
        cyc(4);
        $display("txn abort12: cmd=83 cs raised after 12 bits");
        chk("abort_oe",   bus.o_miso_oe, 0);
        chk("abort_miso", bus.spi_miso, 1);
        cyc(12);
        chk("abort_done",  n_done - d0, 0);
        chk("abort_valid", n_valid - v0, 1);
        read_frame("after_abort", 32'hFFFF_FF0F, 32, 0, '0, '0);

        // Update in the snapshot cycle: old value now, new value next frame.
        update(21'h000001, 3'h0);
        read_frame("snap_old", 32'h0000_0838, 32, 1, 21'h0, 3'h4);
        read_frame("snap_new", 32'h0000_041C, 32, 0, '0, '0);
        update(21'h0, 3'h1);
        read_frame("status1", 32'h0000_0107, 32, 0, '0, '0);

        // Reset in the middle of a response.
        update(21'h1FFFFF, 3'h7);
        sb_q.push_back('{32'hFFFF_FF0F, 5, "rst_mid"});
        send_cmd(8'h83, 0, '0, '0);
        clock_bits(5);
        rst = 1'b1;
        #1;
        $display("txn rst_mid: reset after 5 response bits");
        chk("rstmid_oe",   bus.o_miso_oe, 0);
        chk("rstmid_miso", bus.spi_miso, 1);
        chk("rstmid_busy", bus.o_busy, 0);
        cyc(3);
        rst = 1'b0;
        cyc(3);
        end_cs();
        read_frame("post_rst_shadow", 32'h0000_0000, 32, 0, '0, '0);

        // cs held low across reset release must not start a command.
        v0 = n_valid;
        sb_q.push_back('{32'h0, 0, "cs_low_rst"});
        bus.spi_cs = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(10);
        for (int i = 7; i >= 0; i--) sck_pulse(((8'h83 >> i) & 8'h1) != 0, 0, '0, '0);
        cyc(6);
        $display("txn cs_low_rst: cmd=83 without fresh cs fall");
        chk("cslow_busy",  bus.o_busy, 0);
        chk("cslow_valid", n_valid - v0, 0);
        end_cs();

`ifdef MT6835_EMU_CRC_ERR_INJ_EN
        bus.i_crc_inj = 1'b1;
        update(21'h0, 3'h0);
        read_frame("crc_inj", 32'h0000_00FF, 32, 0, '0, '0);
        bus.i_crc_inj = 1'b0;
        read_frame("crc_ok", 32'h0000_0000, 32, 0, '0, '0);
`endif

        cyc(20);
        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
